// File: rtl/bus_sequencer.sv
// ----------------------------------------------------------------------------
// bus_sequencer
//   Control sequencer for a basic accumulator machine. A timing-step counter
//   walks T0..T6 through fetch, decode and execute. The bus select, register
//   strobes and ALU op are decoded combinationally from the step, the latched
//   indirect bit, the IR and dr_zero.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   ir       : IR contents; [15]=I, [14:12]=opcode, [11:0]=addr/reg-ref bits
//   dr_zero  : DR==0, consulted by ISZ at T6
//   sel      : bus source (0 none,1 AR,2 PC,3 DR,4 AC,5 IR,6 MEM)
//   ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_wr
//            : single-cycle register / memory strobes
//   alu_op   : 0 none,1 AND,2 ADD,3 LOAD,4 CLR,5 CMA,6 INC
//   sc       : current timing step
//   halted   : sticky halt flag, cleared only by rst
// ----------------------------------------------------------------------------
module bus_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        dr_zero,
    output logic [2:0]  sel,
    output logic        ld_ar,
    output logic        inc_ar,
    output logic        ld_pc,
    output logic        inc_pc,
    output logic        ld_dr,
    output logic        inc_dr,
    output logic        ld_ac,
    output logic        ld_ir,
    output logic        mem_wr,
    output logic [2:0]  alu_op,
    output logic [2:0]  sc,
    output logic        halted
);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_MEM  = 3'd6;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_LOAD = 3'd3;
    localparam logic [2:0] ALU_CLR  = 3'd4;
    localparam logic [2:0] ALU_CMA  = 3'd5;
    localparam logic [2:0] ALU_INC  = 3'd6;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_RR  = 3'd7;

    logic [2:0] sc_q, sc_d;
    logic       i_q, i_d;
    logic       halt_q, halt_d;
    logic [2:0] opcode;
    logic       hlt_hit;

    assign opcode = ir[14:12];
    // HLT only fires when no higher-priority register-reference bit is set
    assign hlt_hit = ~ir[11] & ~ir[9] & ~ir[5] & ir[0];

    assign sc     = sc_q;
    assign halted = halt_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q   <= 3'd0;
            i_q    <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            i_q    <= i_d;
            halt_q <= halt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sc_d   = 3'd0;
        i_d    = i_q;
        halt_d = halt_q;
        if (!halt_q) begin
            case (sc_q)
                3'd0: sc_d = 3'd1;
                3'd1: sc_d = 3'd2;
                3'd2: begin
                    sc_d = 3'd3;
                    i_d  = ir[15];
                end
                3'd3: begin
                    if (opcode == OP_RR) begin
                        sc_d = 3'd0;
                        if (!i_q && hlt_hit)
                            halt_d = 1'b1;
                    end else begin
                        sc_d = 3'd4;
                    end
                end
                3'd4: sc_d = (opcode == OP_STA || opcode == OP_BUN) ? 3'd0 : 3'd5;
                3'd5: sc_d = (opcode == OP_ISZ) ? 3'd6 : 3'd0;
                default: sc_d = 3'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode; everything is quiet during reset and while halted
    // ------------------------------------------------------------------
    always_comb begin
        sel    = SEL_NONE;
        alu_op = ALU_NONE;
        ld_ar  = 1'b0;
        inc_ar = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        ld_dr  = 1'b0;
        inc_dr = 1'b0;
        ld_ac  = 1'b0;
        ld_ir  = 1'b0;
        mem_wr = 1'b0;
        if (!rst && !halt_q) begin
            case (sc_q)
                3'd0: begin
                    sel   = SEL_PC;
                    ld_ar = 1'b1;
                end
                3'd1: begin
                    sel    = SEL_MEM;
                    ld_ir  = 1'b1;
                    inc_pc = 1'b1;
                end
                3'd2: begin
                    sel   = SEL_IR;
                    ld_ar = 1'b1;
                end
                3'd3: begin
                    if (opcode == OP_RR) begin
                        if (!i_q) begin
                            if (ir[11]) begin
                                alu_op = ALU_CLR;
                                ld_ac  = 1'b1;
                            end else if (ir[9]) begin
                                alu_op = ALU_CMA;
                                ld_ac  = 1'b1;
                            end else if (ir[5]) begin
                                alu_op = ALU_INC;
                                ld_ac  = 1'b1;
                            end
                        end
                    end else if (i_q) begin
                        // indirect: fetch the effective address into AR
                        sel   = SEL_MEM;
                        ld_ar = 1'b1;
                    end
                end
                3'd4: begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            sel   = SEL_MEM;
                            ld_dr = 1'b1;
                        end
                        OP_STA: begin
                            sel    = SEL_AC;
                            mem_wr = 1'b1;
                        end
                        OP_BUN: begin
                            sel   = SEL_AR;
                            ld_pc = 1'b1;
                        end
                        OP_BSA: begin
                            sel    = SEL_PC;
                            mem_wr = 1'b1;
                            inc_ar = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (opcode)
                        OP_AND: begin alu_op = ALU_AND;  ld_ac = 1'b1; end
                        OP_ADD: begin alu_op = ALU_ADD;  ld_ac = 1'b1; end
                        OP_LDA: begin alu_op = ALU_LOAD; ld_ac = 1'b1; end
                        OP_BSA: begin
                            sel   = SEL_AR;
                            ld_pc = 1'b1;
                        end
                        OP_ISZ: inc_dr = 1'b1;
                        default: ;
                    endcase
                end
                3'd6: begin
                    sel    = SEL_DR;
                    mem_wr = 1'b1;
                    inc_pc = dr_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bus_sequencer
//   Scoreboard bench. The stimulus process plays whole instructions; for each
//   instruction a reference model builds the expected per-cycle output list
//   from the instruction's micro-program, and each cycle's expectation is
//   pushed as the cycle is driven. A monitor on the falling edge pops and
//   compares the full output bundle every cycle.
//   Bundle layout: {sc[2:0], halted, sel[2:0], alu_op[2:0],
//                   ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_wr}
// ----------------------------------------------------------------------------
module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        dr_zero;
    logic [2:0]  sel, alu_op, sc;
    logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_wr;
    logic        halted;

    bus_sequencer dut (
        .clk(clk), .rst(rst), .ir(ir), .dr_zero(dr_zero),
        .sel(sel), .ld_ar(ld_ar), .inc_ar(inc_ar), .ld_pc(ld_pc),
        .inc_pc(inc_pc), .ld_dr(ld_dr), .inc_dr(inc_dr), .ld_ac(ld_ac),
        .ld_ir(ld_ir), .mem_wr(mem_wr), .alu_op(alu_op), .sc(sc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // strobe masks
    localparam logic [8:0] LDAR  = 9'h100;
    localparam logic [8:0] INCAR = 9'h080;
    localparam logic [8:0] LDPC  = 9'h040;
    localparam logic [8:0] INCPC = 9'h020;
    localparam logic [8:0] LDDR  = 9'h010;
    localparam logic [8:0] INCDR = 9'h008;
    localparam logic [8:0] LDAC  = 9'h004;
    localparam logic [8:0] LDIR  = 9'h002;
    localparam logic [8:0] MEMWR = 9'h001;

    logic [18:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wire [18:0] act = {sc, halted, sel, alu_op,
                       ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_wr};

    function automatic logic [18:0] mk(input int s, input bit h, input logic [2:0] sl,
                                       input logic [2:0] al, input logic [8:0] sb);
        logic [2:0] s3;
        s3 = s[2:0];
        return {s3, h, sl, al, sb};
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [18:0] e;
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle_bundle t=%0t ir=%h got sc=%0d h=%0b sel=%0d alu=%0d stb=%b want sc=%0d h=%0b sel=%0d alu=%0d stb=%b",
                         $time, ir, act[18:16], act[15], act[14:12], act[11:9], act[8:0],
                         e[18:16], e[15], e[14:12], e[11:9], e[8:0]);
            end
        end
    end

    // After HLT: ten quiet cycles with random IR, then a reset cycle.
    task automatic halt_seq();
        for (int k = 0; k < 11; k++) begin
            ir      = 16'($urandom);
            dr_zero = 1'($urandom_range(0, 1));
            rst     = (k == 10);
            exp_q.push_back(mk(0, 1'b1, 3'd0, 3'd0, 9'h0));
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Plays one instruction. abort_at >= 0 asserts rst during that step.
    task automatic run_instr(input logic [15:0] iv, input int abort_at, input bit dz6);
        logic [18:0] st[$];
        logic [2:0]  op;
        bit          ib, hlt, aborted;
        op = iv[14:12];
        ib = iv[15];
        hlt = 1'b0;
        aborted = 1'b0;
        // fetch / decode
        st.push_back(mk(0, 0, 3'd2, 3'd0, LDAR));
        st.push_back(mk(1, 0, 3'd6, 3'd0, LDIR | INCPC));
        st.push_back(mk(2, 0, 3'd5, 3'd0, LDAR));
        if (op == 3'd7) begin
            if (ib)             st.push_back(mk(3, 0, 3'd0, 3'd0, 9'h0));
            else if (iv[11])    st.push_back(mk(3, 0, 3'd0, 3'd4, LDAC));
            else if (iv[9])     st.push_back(mk(3, 0, 3'd0, 3'd5, LDAC));
            else if (iv[5])     st.push_back(mk(3, 0, 3'd0, 3'd6, LDAC));
            else begin
                st.push_back(mk(3, 0, 3'd0, 3'd0, 9'h0));
                hlt = iv[0];
            end
        end else begin
            st.push_back(ib ? mk(3, 0, 3'd6, 3'd0, LDAR) : mk(3, 0, 3'd0, 3'd0, 9'h0));
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    st.push_back(mk(4, 0, 3'd6, 3'd0, LDDR));
                    st.push_back(mk(5, 0, 3'd0, 3'(int'(op) + 1), LDAC));
                end
                3'd3: st.push_back(mk(4, 0, 3'd4, 3'd0, MEMWR));
                3'd4: st.push_back(mk(4, 0, 3'd1, 3'd0, LDPC));
                3'd5: begin
                    st.push_back(mk(4, 0, 3'd2, 3'd0, MEMWR | INCAR));
                    st.push_back(mk(5, 0, 3'd1, 3'd0, LDPC));
                end
                default: begin // ISZ
                    st.push_back(mk(4, 0, 3'd6, 3'd0, LDDR));
                    st.push_back(mk(5, 0, 3'd0, 3'd0, INCDR));
                    st.push_back(mk(6, 0, 3'd3, 3'd0, MEMWR | (dz6 ? INCPC : 9'h0)));
                end
            endcase
        end
        for (int k = 0; k < st.size(); k++) begin
            ir      = iv;
            dr_zero = (k == 6) ? dz6 : 1'($urandom_range(0, 1));
            if (k == abort_at) begin
                rst = 1'b1;
                exp_q.push_back(mk(k, 0, 3'd0, 3'd0, 9'h0));
                @(posedge clk); #1;
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            exp_q.push_back(st[k]);
            @(posedge clk); #1;
        end
        if (hlt && !aborted) halt_seq();
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ir = 16'h0; dr_zero = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 3'd0, 3'd0, 9'h0));   // held in reset
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(16'h2123, -1, 1'b0);   // LDA direct
        run_instr(16'hB050, -1, 1'b0);   // STA indirect
        run_instr(16'h6010, -1, 1'b1);   // ISZ, skip
        run_instr(16'h6010, -1, 1'b0);   // ISZ, no skip
        run_instr(16'h7A00, -1, 1'b0);   // CLA wins over CMA
        run_instr(16'h5040,  4, 1'b0);   // BSA aborted by reset at T4
        run_instr(16'h7020, -1, 1'b0);   // INC
        run_instr(16'hF001, -1, 1'b0);   // opcode 7 with I=1: NOP, no halt
        run_instr(16'h4123, -1, 1'b0);   // BUN
        run_instr(16'h7001, -1, 1'b0);   // HLT then reset

        for (int n = 0; n < 400; n++) begin
            logic [15:0] iv;
            int ab;
            iv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) iv[11:0] = 12'h001 << $urandom_range(0, 11);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(iv, ab, 1'($urandom_range(0, 1)));
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
